plot_sink: RTL

- Receiving end of the pixel plot interface (x, y, colour, plot strobe) that the drawing logic drives every CLOCK_50 cycle.
- Clips each plot request against the screen and buffers it in a small FIFO.
- Drains the FIFO into a framebuffer write port, converting (x, y) to a linear address y*WIDTH + x.
- Gives the drawing logic backpressure (ready) and error counters, so dropped or clipped pixels are visible instead of silently lost.

---
 rtl/plot_sink.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/plot_sink.sv
// Pixel plot receiver: clips requests against the screen, queues them in a small FIFO
// and drains them into a framebuffer write port, counting clipped and dropped pixels.
module plot_sink #(
   parameter int WIDTH  = 160,
   parameter int HEIGHT = 120,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 15
) (
   input  logic                      CLOCK_50,
   input  logic                      reset,
   input  logic [7:0]                x,
   input  logic [6:0]                y,
   input  logic [2:0]                colour,
   input  logic                      plot,
   output logic                      ready,
   input  logic                      fb_stall,
   output logic [ADDR_W-1:0]         fb_addr,
   output logic [2:0]                fb_data,
   output logic                      fb_we,
   output logic [$clog2(DEPTH):0]    pending,
   output logic [7:0]                drop_count,
   output logic [7:0]                clip_count,
   output logic                      overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int ENT_W = 18;
   localparam logic [8:0]        WIDTH_C  = 9'(WIDTH);
   localparam logic [7:0]        HEIGHT_C = 8'(HEIGHT);
   localparam logic [PTR_W:0]    DEPTH_C  = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
   localparam logic [ADDR_W-1:0] WIDTH_A  = ADDR_W'(WIDTH);

   logic [ENT_W-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    count_q, count_d;
   logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
   logic [2:0]        fb_data_q, fb_data_d;
   logic              fb_we_q, fb_we_d;
   logic [7:0]        drop_count_q, drop_count_d;
   logic [7:0]        clip_count_q, clip_count_d;
   logic              overflow_q, overflow_d;

   logic              full_s, empty_s, on_screen_s, push_s, pop_s, clip_s, drop_s;
   logic [ENT_W-1:0]  rd_ent_s;
   logic [7:0]        rd_x_s;
   logic [6:0]        rd_y_s;
   logic [2:0]        rd_colour_s;

   assign full_s      = (count_q == DEPTH_C);
   assign empty_s     = (count_q == '0);
   assign on_screen_s = ({1'b0, x} < WIDTH_C) && ({1'b0, y} < HEIGHT_C);
   // Clip is judged before full, so off-screen requests never count as drops.
   assign clip_s      = plot && !on_screen_s;
   assign drop_s      = plot && on_screen_s && full_s;
   assign push_s      = plot && on_screen_s && !full_s;
   assign pop_s       = !empty_s && !fb_stall;

   assign rd_ent_s    = mem_q[rd_ptr_q];
   assign rd_x_s      = rd_ent_s[17:10];
   assign rd_y_s      = rd_ent_s[9:3];
   assign rd_colour_s = rd_ent_s[2:0];

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      fb_addr_d    = fb_addr_q;
      fb_data_d    = fb_data_q;
      fb_we_d      = 1'b0;
      drop_count_d = drop_count_q;
      clip_count_d = clip_count_q;
      overflow_d   = overflow_q;

      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d  = rd_ptr_q + PTR_ONE;
         fb_addr_d = ADDR_W'(rd_y_s) * WIDTH_A + ADDR_W'(rd_x_s);
         fb_data_d = rd_colour_s;
         fb_we_d   = 1'b1;
      end else begin
         rd_ptr_d  = rd_ptr_q;
      end

      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      if (clip_s && (clip_count_q != 8'hFF)) begin
         clip_count_d = clip_count_q + 8'd1;
      end else begin
         clip_count_d = clip_count_q;
      end

      if (drop_s) begin
         overflow_d = 1'b1;
         if (drop_count_q != 8'hFF) begin
            drop_count_d = drop_count_q + 8'd1;
         end else begin
            drop_count_d = drop_count_q;
         end
      end else begin
         overflow_d   = overflow_q;
         drop_count_d = drop_count_q;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         fb_addr_q    <= '0;
         fb_data_q    <= 3'b000;
         fb_we_q      <= 1'b0;
         drop_count_q <= 8'd0;
         clip_count_q <= 8'd0;
         overflow_q   <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         fb_addr_q    <= fb_addr_d;
         fb_data_q    <= fb_data_d;
         fb_we_q      <= fb_we_d;
         drop_count_q <= drop_count_d;
         clip_count_q <= clip_count_d;
         overflow_q   <= overflow_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge CLOCK_50) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= {x, y, colour};
      end
   end

   assign ready      = !full_s;
   assign fb_addr    = fb_addr_q;
   assign fb_data    = fb_data_q;
   assign fb_we      = fb_we_q;
   assign pending    = count_q;
   assign drop_count = drop_count_q;
   assign clip_count = clip_count_q;
   assign overflow   = overflow_q;

endmodule
